// File: rtl/bram_arbiter_pkg.sv
// Shared encodings for the BRAM arbiter: FSM states, read-owner tags and
// default widths.
package bram_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_COMPUTE   = 2'd0,
    ST_VGA_FORCE = 2'd1,
    ST_DISPLAY   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/bram_arbiter_bram.sv
// Single-port synchronous BRAM, read latency 1, read-before-write.
// The contents are not reset; only the address/data path is registered.
module bram_arbiter_bram #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     ram_enable,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  output logic [RAM_WIDTH-1:0]     output_data
);

  logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];
  logic [RAM_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (ram_enable) begin
      if (write_enable) begin
        mem[address] <= input_data;
      end
      dout_q <= mem[address];
    end
  end

  assign output_data = dout_q;

endmodule

// File: rtl/bram_arbiter.sv
// Shares the single BRAM port between the CPU memory stage and the VGA scan
// reader; display_mode selects CPU-priority (with starvation guard) or VGA-only.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              cpu_wr_dropped,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  rd_owner_t           owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]   vga_hold_q, vga_hold_d;
  logic                cpu_gnt_c, vga_gnt_c, wr_drop_c;
  logic [DATA_W-1:0]   bram_dout;

  // Handshake: a request is held until its *_gnt is seen high in the same
  // cycle; reads then return *_rvalid/*_rdata exactly one cycle later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpu_gnt_c = 1'b0;
    vga_gnt_c = 1'b0;
    wr_drop_c = 1'b0;
    case (state_q)
      ST_COMPUTE: begin
        if (cpu_req)      cpu_gnt_c = 1'b1;
        else if (vga_req) vga_gnt_c = 1'b1;
        if (vga_gnt_c || !vga_req) cnt_d = '0;
        else if (cpu_gnt_c)        cnt_d = cnt_q + 4'd1;
        // Force is decided on the updated count so VGA gets the very next slot.
        if (display_mode) begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
        end else if (vga_req && cnt_d == STARVE_LIM) begin
          state_d = ST_VGA_FORCE;
        end
      end
      ST_VGA_FORCE: begin
        vga_gnt_c = vga_req;
        cnt_d     = '0;
        state_d   = display_mode ? ST_DISPLAY : ST_COMPUTE;
      end
      ST_DISPLAY: begin
        if (vga_req)                  vga_gnt_c = 1'b1;
        else if (cpu_req && !cpu_we)  cpu_gnt_c = 1'b1;
        wr_drop_c = cpu_req & cpu_we;
        cnt_d     = '0;
        if (!display_mode) state_d = ST_COMPUTE;
      end
      default: begin
        state_d = ST_COMPUTE;
        cnt_d   = '0;
      end
    endcase
    // Outputs must read zero while reset is asserted, even with requests high.
    if (!rst) begin
      cpu_gnt_c = 1'b0;
      vga_gnt_c = 1'b0;
      wr_drop_c = 1'b0;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    owner_d = OWN_NONE;
    if (cpu_gnt_c) begin
      addr_d = cpu_addr;
      if (!cpu_we) owner_d = OWN_CPU;
    end else if (vga_gnt_c) begin
      addr_d  = vga_addr;
      owner_d = OWN_VGA;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign vga_rvalid = (owner_q == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? bram_dout : cpu_hold_q;
  assign vga_rdata  = vga_rvalid ? bram_dout : vga_hold_q;
  assign cpu_hold_d = cpu_rdata;
  assign vga_hold_d = vga_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_COMPUTE;
      cnt_q      <= '0;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      cpu_hold_q <= '0;
      vga_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      cpu_hold_q <= cpu_hold_d;
      vga_hold_q <= vga_hold_d;
    end
  end

  assign cpu_gnt        = cpu_gnt_c;
  assign vga_gnt        = vga_gnt_c;
  assign cpu_wr_dropped = wr_drop_c;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = cnt_q;

  bram_arbiter_bram #(
    .RAM_WIDTH     (DATA_W),
    .RAM_ADDR_BITS (ADDR_W)
  ) u_bram (
    .clk          (clk),
    .ram_enable   (1'b1),
    .write_enable (cpu_gnt_c & cpu_we),
    .address      (addr_d),
    .input_data   (cpu_wdata),
    .output_data  (bram_dout)
  );

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising edge.
module tb_bram_arbiter;

  logic        clk;
  logic        rst;
  logic        display_mode;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_gnt, vga_rvalid;
  logic [7:0]  vga_rdata;
  logic        cpu_wr_dropped;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .display_mode(display_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_wr_dropped(cpu_wr_dropped), .dbg_state(dbg_state),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; display_mode = 1'b0; idle_inputs();
    next_cycle(); #1;
    if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_gnt: got %b exp 0", cpu_gnt); end n_cmp++;
    if (vga_gnt !== 1'b0) begin n_err++; $display("FAIL rst_vga_gnt: got %b exp 0", vga_gnt); end n_cmp++;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rvalid: got %b exp 0", cpu_rvalid); end n_cmp++;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_vga_rvalid: got %b exp 0", vga_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_cpu_rdata: got %h exp 00", cpu_rdata); end n_cmp++;
    if (vga_rdata !== 8'h00) begin n_err++; $display("FAIL rst_vga_rdata: got %h exp 00", vga_rdata); end n_cmp++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end n_cmp++;
    if (dbg_starve_cnt !== 4'd0) begin n_err++; $display("FAIL rst_starve: got %0d exp 0", dbg_starve_cnt); end n_cmp++;
    rst = 1'b1;
    next_cycle();
  endtask

  // Write one byte in compute mode; the grant is checked in passing.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL preload_gnt @%h: got %b exp 1", a, cpu_gnt); end n_cmp++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b exp 1", cpu_gnt); end n_cmp++;
    next_cycle();
    cpu_we = 1'b0;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b exp 1", cpu_gnt); end n_cmp++;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b exp 0", cpu_rvalid); end n_cmp++;
    next_cycle();
    idle_inputs();
    #1;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b exp 1", cpu_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL rd_data: got %h exp 5a", cpu_rdata); end n_cmp++;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_vga_quiet: got %b exp 0", vga_rvalid); end n_cmp++;
    next_cycle(); #1;
    if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop: got %b exp 0", cpu_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL rd_data_hold: got %h exp 5a", cpu_rdata); end n_cmp++;
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_vga, exp_rv;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    vga_req = 1'b1; vga_addr = 16'h0100;
    for (int k = 0; k < 11; k++) begin
      exp_vga = (k % 5 == 4);
      exp_rv  = (k > 0) && ((k - 1) % 5 == 4);
      #1;
      if (vga_gnt !== exp_vga) begin n_err++; $display("FAIL starve_vga_gnt[%0d]: got %b exp %b", k, vga_gnt, exp_vga); end n_cmp++;
      if (cpu_gnt !== !exp_vga) begin n_err++; $display("FAIL starve_cpu_gnt[%0d]: got %b exp %b", k, cpu_gnt, !exp_vga); end n_cmp++;
      if (vga_rvalid !== exp_rv) begin n_err++; $display("FAIL starve_vga_rvalid[%0d]: got %b exp %b", k, vga_rvalid, exp_rv); end n_cmp++;
      if (exp_rv && vga_rdata !== 8'hA5) begin n_err++; $display("FAIL starve_vga_rdata[%0d]: got %h exp a5", k, vga_rdata); end
      if (exp_rv) n_cmp++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_display_write_block();
    display_mode = 1'b1;
    next_cycle(); #1;
    if (dbg_state !== 2'd2) begin n_err++; $display("FAIL disp_enter_state: got %0d exp 2", dbg_state); end n_cmp++;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL disp_wr_gnt[%0d]: got %b exp 0", k, cpu_gnt); end n_cmp++;
      if (cpu_wr_dropped !== 1'b1) begin n_err++; $display("FAIL disp_wr_drop[%0d]: got %b exp 1", k, cpu_wr_dropped); end n_cmp++;
      next_cycle();
    end
    idle_inputs();
    #1;
    if (cpu_wr_dropped !== 1'b0) begin n_err++; $display("FAIL disp_drop_end: got %b exp 0", cpu_wr_dropped); end n_cmp++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL disp_rd_gnt: got %b exp 1", cpu_gnt); end n_cmp++;
    next_cycle();
    idle_inputs();
    #1;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL disp_rd_rvalid: got %b exp 1", cpu_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h33) begin n_err++; $display("FAIL disp_rd_old: got %h exp 33", cpu_rdata); end n_cmp++;
    next_cycle();
  endtask

  task automatic test_display_priority();
    vga_req = 1'b1; vga_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    if (vga_gnt !== 1'b1) begin n_err++; $display("FAIL prio_vga_gnt: got %b exp 1", vga_gnt); end n_cmp++;
    if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL prio_cpu_held: got %b exp 0", cpu_gnt); end n_cmp++;
    next_cycle();
    vga_req = 1'b0;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL prio_cpu_gnt: got %b exp 1", cpu_gnt); end n_cmp++;
    if (vga_rvalid !== 1'b1) begin n_err++; $display("FAIL prio_vga_rvalid: got %b exp 1", vga_rvalid); end n_cmp++;
    if (vga_rdata !== 8'hA5) begin n_err++; $display("FAIL prio_vga_rdata: got %h exp a5", vga_rdata); end n_cmp++;
    next_cycle();
    idle_inputs();
    #1;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL prio_cpu_rvalid: got %b exp 1", cpu_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL prio_cpu_rdata: got %h exp 5a", cpu_rdata); end n_cmp++;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL prio_vga_quiet: got %b exp 0", vga_rvalid); end n_cmp++;
    next_cycle();
  endtask

  task automatic test_mode_switch();
    display_mode = 1'b0;
    next_cycle(); #1;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL sw_back_state: got %0d exp 0", dbg_state); end n_cmp++;
    if (dbg_starve_cnt !== 4'd0) begin n_err++; $display("FAIL sw_back_starve: got %0d exp 0", dbg_starve_cnt); end n_cmp++;
    display_mode = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    vga_req = 1'b1; vga_addr = 16'h0100;
    #1;
    if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL sw_cpu_gnt: got %b exp 1", cpu_gnt); end n_cmp++;
    if (vga_gnt !== 1'b0) begin n_err++; $display("FAIL sw_vga_gnt: got %b exp 0", vga_gnt); end n_cmp++;
    next_cycle();
    idle_inputs();
    #1;
    if (dbg_state !== 2'd2) begin n_err++; $display("FAIL sw_state: got %0d exp 2", dbg_state); end n_cmp++;
    if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL sw_cpu_rvalid: got %b exp 1", cpu_rvalid); end n_cmp++;
    if (cpu_rdata !== 8'h33) begin n_err++; $display("FAIL sw_cpu_rdata: got %h exp 33", cpu_rdata); end n_cmp++;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL sw_vga_rvalid: got %b exp 0", vga_rvalid); end n_cmp++;
    display_mode = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    vga_req = 1'b1; vga_addr = 16'h0100;
    #1;
    if (vga_gnt !== 1'b1) begin n_err++; $display("FAIL mid_vga_gnt: got %b exp 1", vga_gnt); end n_cmp++;
    @(posedge clk); #2;
    if (vga_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b exp 1", vga_rvalid); end n_cmp++;
    vga_req = 1'b0;
    rst = 1'b0;
    #1;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_vga_rvalid: got %b exp 0", vga_rvalid); end n_cmp++;
    if (vga_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_vga_rdata: got %h exp 00", vga_rdata); end n_cmp++;
    if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_cpu_rdata: got %h exp 00", cpu_rdata); end n_cmp++;
    if (vga_gnt !== 1'b0) begin n_err++; $display("FAIL mid_rst_vga_gnt: got %b exp 0", vga_gnt); end n_cmp++;
    next_cycle();
    rst = 1'b1;
    next_cycle(); #1;
    if (vga_rvalid !== 1'b0) begin n_err++; $display("FAIL post_rst_rvalid: got %b exp 0", vga_rvalid); end n_cmp++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL post_rst_state: got %0d exp 0", dbg_state); end n_cmp++;
    if (dbg_starve_cnt !== 4'd0) begin n_err++; $display("FAIL post_rst_starve: got %0d exp 0", dbg_starve_cnt); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    cpu_write(16'h0100, 8'hA5);
    cpu_write(16'h0020, 8'h33);
    next_cycle();
    test_starvation();
    test_display_write_block();
    test_display_priority();
    test_mode_switch();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Owns the 64K x 8 frame/data BRAM and shares its single port between two requesters: the CPU memory-write stage (loads and stores) and the VGA scan reader.
- The display-mode input selects the sharing policy. In compute mode the CPU has priority, with a starvation guard for VGA. In display mode VGA has absolute priority and CPU writes are blocked.
- Sits between the execute/memory stage and the existing bram module, replacing the direct address/write muxing in the memory stage.

Parameters:
ADDR_W, 16, BRAM address width (depth = 2^ADDR_W)
DATA_W, 8, BRAM data width
STARVE_MAX, 4, max consecutive CPU grants while vga_req is pending before VGA is forced a slot (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
display_mode  in  1  1 = frame output phase (VGA priority, CPU writes blocked); 0 = compute phase
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data (already saturated upstream)
cpu_gnt  out  1  CPU access performed this cycle
cpu_rvalid  out  1  CPU read data valid (one cycle after read grant)
cpu_rdata  out  DATA_W  CPU read data
vga_req  in  1  VGA pixel read request
vga_addr  in  ADDR_W  VGA pixel address
vga_gnt  out  1  VGA access performed this cycle
vga_rvalid  out  1  VGA read data valid
vga_rdata  out  DATA_W  VGA read data
cpu_wr_dropped  out  1  pulse: CPU write request refused because display_mode=1

Behaviour:
- Reset (rst=0, async): FSM=COMPUTE, starve_cnt=0, rd_owner=NONE; all outputs 0, rdata outputs 0.
- Grants are combinational from requests, current state and starve_cnt. At most one grant per cycle. The bram port is driven from the granted requester in the same cycle.
- bram read latency is 1. rd_owner is registered on each read grant. On the next cycle the matching *_rvalid=1 and *_rdata=bram output. The non-owner's rdata holds its last value. Writes never produce rvalid.
- Idle cycle (no grant): bram write_enable=0 and address holds its previous value.
- FSM states:
  - COMPUTE:
    - cpu_req → cpu_gnt.
    - Else vga_req → vga_gnt.
    - starve_cnt increments on each CPU grant while vga_req=1.
    - When starve_cnt==STARVE_MAX and vga_req=1, go to VGA_FORCE.
    - starve_cnt clears on any VGA grant, or on any cycle with vga_req=0.
    - display_mode=1 → DISPLAY.
  - VGA_FORCE:
    - Lasts exactly one cycle. vga_gnt=1 if vga_req, cpu_gnt=0, starve_cnt cleared.
    - Next state is COMPUTE, or DISPLAY if display_mode=1.
  - DISPLAY:
    - vga_req → vga_gnt.
    - Else a CPU read (cpu_req & !cpu_we) → cpu_gnt.
    - A CPU write is never granted. Each cycle with cpu_req & cpu_we pulses cpu_wr_dropped=1 for one cycle, and the request stays ungranted.
    - display_mode=0 → COMPUTE with starve_cnt=0.
- display_mode changing mid-operation: a read already granted still delivers its rvalid on the next cycle to the recorded owner, independent of state.
- The new policy applies from the cycle after display_mode is sampled high. In the sampling cycle itself, COMPUTE rules still apply.
- Simultaneous cpu_req and vga_req with starve_cnt<STARVE_MAX in COMPUTE: CPU wins.
- Address wrap: addresses are taken modulo 2^ADDR_W. No range check.
- Back-to-back reads by alternating owners are legal every cycle. rvalid follows each grant with latency 1.

Decomposition:
- Shared package:
  - FSM state encoding: COMPUTE=2'd0, VGA_FORCE=2'd1, DISPLAY=2'd2.
  - Owner encoding: NONE/CPU/VGA.
  - Default width constants: ADDR_W=16, DATA_W=8.
- One sub-module: the existing bram, instantiated internally with RAM_WIDTH=DATA_W, RAM_ADDR_BITS=ADDR_W, ram_enable tied 1.
- Arbitration FSM, starvation counter and rvalid/owner pipeline are inline.

Test Plan:
- Reset release, COMPUTE: CPU write addr 0x0010 data 0x5A, then CPU read 0x0010 → cpu_gnt each cycle; cpu_rvalid=1 with cpu_rdata=0x5A exactly one cycle after the read grant.
- COMPUTE, cpu_req and vga_req both held high continuously, STARVE_MAX=4 → grant pattern CPU,CPU,CPU,CPU,VGA repeating; vga_rvalid one cycle after each VGA grant.
- display_mode=1, CPU write to 0x0020 held 3 cycles → cpu_gnt=0, cpu_wr_dropped high 3 cycles; a later read of 0x0020 returns the old value.
- display_mode=1, vga_req plus CPU read both high → VGA granted. Drop vga_req → CPU read granted next cycle, cpu_rvalid the cycle after.
- CPU read granted on the cycle display_mode rises → cpu_rvalid still asserted the next cycle with correct data, and no vga_rvalid in that cycle.
- rst pulled low while a VGA read is pending rvalid → all outputs 0 immediately (async). After release, no stale vga_rvalid; state is COMPUTE and starve_cnt=0.
